// File: rtl/data_memory_responder.sv
// data_memory_responder
//
// Responder end of the CPU data-memory interface. It takes one load or store
// at a time over a valid/ready request handshake. It then waits WAIT_CYCLES
// wait states and performs the access on an internal array of 64-bit words.
// The result goes back over a valid/ready response handshake.
//
// Parameters:
//   DEPTH        number of 64-bit words; valid word indices 0..DEPTH-1
//   WAIT_CYCLES  wait states between request acceptance and access (0..255)
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   req_valid    request present
//   req_ready    responder can accept a request (registered)
//   req_write    1 = store, 0 = load
//   req_address  byte address; the word index is address[63:3]
//   req_data     store data
//   resp_valid   response present
//   resp_ready   initiator accepts the response
//   resp_data    load data; 0 for stores and errors
//   resp_error   request rejected (out of range or misaligned)
//
// Build option:
//   DMEM_ALIGN_CHECK_EN  when defined, an address with bits [2:0] != 0 is
//                        rejected with resp_error. When undefined, those
//                        bits are ignored.
module data_memory_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_address,
  input  logic [63:0] req_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        resp_error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESPOND
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_error_q, resp_error_d;
  logic [63:0] resp_data_q, resp_data_d;

  // Latched request; pure data, so it is not reset.
  logic        lat_write_q;
  logic [63:0] lat_addr_q;
  logic [63:0] lat_data_q;

  // Array contents are not reset.
  logic [63:0] mem_q [DEPTH];

  logic        accept;
  logic        enter_respond;
  logic        acc_write;
  logic [63:0] acc_addr;
  logic [63:0] acc_data;
  logic [60:0] word_idx;
  logic [IDX_W-1:0] mem_idx;
  logic        in_range;
  logic        low_nz;
  logic        err_misalign;
  logic        acc_err;
  logic        commit;

  assign accept = (state_q == S_IDLE) && req_valid && req_ready_q;

  // With zero wait states, the access happens on the accept edge itself.
  // The latch is not loaded until that same edge, so the operands come
  // straight from the request ports while in IDLE.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_address;
      acc_data  = req_data;
    end else begin
      acc_write = lat_write_q;
      acc_addr  = lat_addr_q;
      acc_data  = lat_data_q;
    end
  end

  assign word_idx = acc_addr[63:3];
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign in_range = (word_idx < 61'(DEPTH));
  assign low_nz   = |acc_addr[2:0];

`ifdef DMEM_ALIGN_CHECK_EN
  assign err_misalign = low_nz;
`else
  logic unused_low_nz;
  assign unused_low_nz = low_nz;
  assign err_misalign  = 1'b0;
`endif

  assign acc_err = !in_range || err_misalign;
  assign commit  = enter_respond && acc_write && !acc_err;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_ready_d   = req_ready_q;
    resp_valid_d  = resp_valid_q;
    resp_error_d  = resp_error_q;
    resp_data_d   = resp_data_q;
    enter_respond = 1'b0;

    case (state_q)
      S_IDLE: begin
        // req_ready_q is 0 straight out of reset and rises on the next edge.
        req_ready_d = 1'b1;
        if (accept) begin
          req_ready_d = 1'b0;
          cnt_d       = 8'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d       = S_RESPOND;
            enter_respond = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd1) begin
          state_d       = S_RESPOND;
          cnt_d         = 8'd0;
          enter_respond = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RESPOND: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          req_ready_d  = 1'b1;
          resp_valid_d = 1'b0;
          resp_error_d = 1'b0;
          resp_data_d  = 64'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (enter_respond) begin
      resp_valid_d = 1'b1;
      resp_error_d = acc_err;
      resp_data_d  = (acc_err || acc_write) ? 64'd0 : mem_q[mem_idx];
    end
  end

  // Control and response registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_data_q  <= 64'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Request latch and array write. A store is only committed on the edge
  // that enters RESPOND. A reset before that edge therefore drops it.
  always_ff @(posedge clock) begin
    if (accept) begin
      lat_write_q <= req_write;
      lat_addr_q  <= req_address;
      lat_data_q  <= req_data;
    end
    if (commit) begin
      mem_q[mem_idx] <= acc_data;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_error = resp_error_q;

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

  localparam int DEPTH = 64;
  localparam int W     = 2;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_address, req_data;
  logic        resp_valid, resp_ready, resp_error;
  logic [63:0] resp_data;

  // Second instance built with no wait states.
  logic        d0_req_valid, d0_req_ready, d0_req_write;
  logic [63:0] d0_req_address, d0_req_data;
  logic        d0_resp_valid, d0_resp_ready, d0_resp_error;
  logic [63:0] d0_resp_data;

  always #5 clock = ~clock;

  data_memory_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_error(resp_error)
  );

  data_memory_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset),
    .req_valid(d0_req_valid), .req_ready(d0_req_ready), .req_write(d0_req_write),
    .req_address(d0_req_address), .req_data(d0_req_data),
    .resp_valid(d0_resp_valid), .resp_ready(d0_resp_ready),
    .resp_data(d0_resp_data), .resp_error(d0_resp_error)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [63:0] mem_m [DEPTH];
  logic        exp_ready, exp_valid, exp_err;
  logic [63:0] exp_data;
  bit          pend;
  longint      edge_n = 0;
  longint      due;
  logic        m_wr;
  logic [63:0] m_addr, m_data;

  task automatic model_access();
    logic [60:0] widx;
    bit          err;
    widx      = m_addr[63:3];
    err       = (widx >= 61'(DEPTH)) || (ALIGN && (m_addr[2:0] != 3'd0));
    pend      = 1'b0;
    exp_valid = 1'b1;
    exp_err   = err;
    exp_data  = 64'd0;
    if (!err) begin
      if (m_wr) mem_m[int'(widx[15:0])] = m_data;
      else      exp_data = mem_m[int'(widx[15:0])];
    end
  endtask

  // The response appears W edges after the accepting edge. It clears on
  // the handshake edge. Ready is high whenever no request is outstanding.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_ready = 1'b0;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      exp_data  = 64'd0;
      pend      = 1'b0;
    end else begin
      edge_n++;
      if (exp_valid) begin
        if (resp_ready) begin
          exp_valid = 1'b0;
          exp_err   = 1'b0;
          exp_data  = 64'd0;
          exp_ready = 1'b1;
        end
      end else if (pend) begin
        if (edge_n == due) model_access();
      end else if (exp_ready && req_valid) begin
        m_wr      = req_write;
        m_addr    = req_address;
        m_data    = req_data;
        pend      = 1'b1;
        exp_ready = 1'b0;
        due       = edge_n + W;
        if (W == 0) model_access();
      end else begin
        exp_ready = 1'b1;
      end
    end
  end

  // Per-cycle compare of the main instance against the model.
  bit cmp_en = 1'b0;
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("req_ready",  64'(req_ready),  64'(exp_ready));
      chk("resp_valid", 64'(resp_valid), 64'(exp_valid));
      chk("resp_error", 64'(resp_error), 64'(exp_err));
      chk("resp_data",  resp_data,       exp_data);
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic wr, input logic [63:0] addr, input logic [63:0] data,
                        input int stall, output logic [63:0] rdata, output logic rerr);
    int n;
    int lat;
    rdata       = 64'd0;
    rerr        = 1'b0;
    req_write   = wr;
    req_address = addr;
    req_data    = data;
    req_valid   = 1'b1;
    resp_ready  = (stall == 0);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n == 50) begin
      chk("accept_timeout", 64'd1, 64'd0);
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    // Junk on the request port must be ignored while busy.
    req_valid   = 1'b0;
    req_write   = 1'($urandom);
    req_address = {$urandom, $urandom};
    req_data    = {$urandom, $urandom};
    lat = 0;
    while (!resp_valid && lat < 300) begin
      @(negedge clock);
      lat++;
    end
    chk("resp_latency", 64'(lat), 64'(W));
    if (lat == 300) return;
    repeat (stall) @(negedge clock);
    resp_ready = 1'b1;
    rdata      = resp_data;
    rerr       = resp_error;
    @(negedge clock);
    resp_ready = 1'b0;
    chk("valid_cleared", 64'(resp_valid), 64'd0);
    chk("ready_back",    64'(req_ready),  64'd1);
  endtask

  logic [63:0] rd;
  logic        re;
  logic [63:0] addr_r;
  logic [63:0] d0_word;
  int          sel, stall_r, n0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_address = 64'd0; req_data = 64'd0;
    resp_ready = 1'b0;
    d0_req_valid = 1'b0; d0_req_write = 1'b0; d0_req_address = 64'd0;
    d0_req_data = 64'd0; d0_resp_ready = 1'b0;
    repeat (2) @(negedge clock);
    cmp_en = 1'b1;
    chk("rst_req_ready",  64'(req_ready),  64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data",  resp_data,       64'd0);
    chk("rst_resp_error", 64'(resp_error), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++)
      do_req(1'b1, 64'(i) * 64'd8, {$urandom, $urandom}, 0, rd, re);

    // Store then load back-to-back.
    do_req(1'b1, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, 0, rd, re);
    chk("st10_data", rd, 64'd0);
    chk("st10_err",  64'(re), 64'd0);
    do_req(1'b0, 64'h10, 64'd0, 0, rd, re);
    chk("ld10_data", rd, 64'hDEAD_BEEF_CAFE_F00D);
    chk("ld10_err",  64'(re), 64'd0);

    // Out-of-range store must not disturb the last word.
    do_req(1'b1, 64'h1F8, 64'h0123_4567_89AB_CDEF, 0, rd, re);
    do_req(1'b1, 64'h200, 64'hFFFF_FFFF_FFFF_FFFF, 0, rd, re);
    chk("oor_data", rd, 64'd0);
    chk("oor_err",  64'(re), 64'd1);
    do_req(1'b0, 64'h1F8, 64'd0, 0, rd, re);
    chk("ld1f8_data", rd, 64'h0123_4567_89AB_CDEF);
    chk("ld1f8_err",  64'(re), 64'd0);

    // Response held for 5 cycles with resp_ready low.
    do_req(1'b0, 64'h10, 64'd0, 5, rd, re);
    chk("stall_data", rd, 64'hDEAD_BEEF_CAFE_F00D);
    chk("stall_err",  64'(re), 64'd0);

    // Reset while a store waits: it must never commit.
    do_req(1'b1, 64'h08, 64'h5555_AAAA_5555_AAAA, 0, rd, re);
    req_write = 1'b1; req_address = 64'h08; req_data = 64'h1234; req_valid = 1'b1;
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midrst_req_ready",  64'(req_ready),  64'd0);
    chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst_resp_data",  resp_data,       64'd0);
    chk("midrst_resp_error", 64'(resp_error), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    resp_ready = 1'b0;
    @(negedge clock);
    chk("midrst_ready_back", 64'(req_ready), 64'd1);
    do_req(1'b0, 64'h08, 64'd0, 0, rd, re);
    chk("midrst_ld08", rd, 64'h5555_AAAA_5555_AAAA);

    // Sub-word address: rejected only with alignment checking.
    do_req(1'b0, 64'h0C, 64'd0, 0, rd, re);
    chk("ld0c_err",  64'(re), ALIGN ? 64'd1 : 64'd0);
    chk("ld0c_data", rd,      ALIGN ? 64'd0 : 64'h5555_AAAA_5555_AAAA);

    // Random traffic against the model.
    for (int k = 0; k < 200; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)
        addr_r = 64'h200 + (64'($urandom_range(0, 4095)) << 3);
      else if (sel == 1)
        addr_r = {$urandom, $urandom};
      else if (sel == 2)
        addr_r = (64'($urandom_range(0, DEPTH - 1)) << 3) | 64'($urandom_range(0, 7));
      else
        addr_r = 64'($urandom_range(0, DEPTH - 1)) << 3;
      stall_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      do_req(1'($urandom), addr_r, {$urandom, $urandom}, stall_r, rd, re);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    // Zero-wait-state instance: the response is visible right after the
    // accepting edge.
    d0_word = 64'hA5A5_0000_1111_5A5A;
    d0_req_valid = 1'b1; d0_req_write = 1'b1; d0_req_address = 64'h18;
    d0_req_data = d0_word; d0_resp_ready = 1'b1;
    n0 = 0;
    while (!d0_req_ready && n0 < 20) begin @(negedge clock); n0++; end
    chk("w0_accept_timeout", 64'(n0 == 20), 64'd0);
    @(posedge clock);
    #1;
    chk("w0_st_valid", 64'(d0_resp_valid), 64'd1);
    chk("w0_st_ready", 64'(d0_req_ready),  64'd0);
    chk("w0_st_err",   64'(d0_resp_error), 64'd0);
    d0_req_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("w0_st_done", 64'(d0_resp_valid), 64'd0);
    chk("w0_rdy_back", 64'(d0_req_ready), 64'd1);
    d0_req_valid = 1'b1; d0_req_write = 1'b0; d0_req_data = 64'd0;
    @(posedge clock);
    #1;
    chk("w0_ld_valid", 64'(d0_resp_valid), 64'd1);
    chk("w0_ld_data",  d0_resp_data,       d0_word);
    d0_req_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("w0_ld_done", 64'(d0_resp_valid), 64'd0);

    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
